seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed driver for a common-segment, DIGITS-wide 7-segment display. It holds one hex nibble, decimal point and blank bit per digit in double-buffered registers and scans the digits one at a time. Each digit period starts with a ghost-suppression gap. The block sits between the CPU's output-port logic and the board's segment and common pins, and replaces direct per-digit drive from `drv7seg`.

## Interface
Parameters:
- `DIGITS`, 4: number of digits; legal range 1..8.
- `SCAN_DIV`, 10000: clock cycles per digit period; must be ≥ 2.
- `GAP`, 16: blanking cycles at the start of each digit period; must satisfy 0 ≤ GAP < SCAN_DIV.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  4*DIGITS  nibble i drives digit i; digit 0 is the least significant.
- `dp`  in  DIGITS  decimal point per digit.
- `blank`  in  DIGITS  per-digit blank request; 1 forces the digit dark, including its dp.
- `lzs`  in  1  leading-zero suppression request; used only with SEG7_LZS_EN.
- `load`  in  1  one-cycle strobe that captures value/dp/blank.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active high.
- `com`  out  DIGITS  one-hot digit enable, active high.
- `frame`  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Two register sets:
  - staging: written by `load`.
  - shadow: drives the display.
- Staging is copied to shadow at the frame boundary, i.e. the cycle where cnt==SCAN_DIV-1 and idx==DIGITS-1.
- Simultaneous `load` and frame boundary: the incoming inputs are written to both staging and shadow, so the new data bypasses the old staging contents.
- Scan counter `cnt` runs 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and digit index `idx` advances, wrapping from DIGITS-1 to 0.
- Two phases per digit:
  - GAP phase (cnt < GAP): com=0, seg=0.
  - ON phase (cnt ≥ GAP): com = one-hot(idx), seg = {shadow dp[idx], pattern(shadow value[idx])}.
  - If shadow blank[idx]=1 in the ON phase: seg=0 and com still asserts.
- Hex pattern (gfedcba), all 16 values:
  - 0=3F, 1=06, 2=5B, 3=4F
  - 4=66, 5=6D, 6=7D, 7=27
  - 8=7F, 9=6F, A=77, B=7C
  - C=58, D=5E, E=79, F=71
- `frame` asserts for exactly one cycle, on the cycle after the frame boundary.
- DIGITS=1: `com` is constant 1 during the ON phase, and `frame` pulses once per digit period.

## Timing
- Reset values (asynchronous):
  - seg=0, com=0, frame=0, cnt=0, idx=0.
  - staging and shadow value=0, dp=0, blank=all-ones, so the display is dark until the first load has propagated.
- `seg`, `com` and `frame` are registered: they reflect the cnt/idx state of the previous cycle.
- After reset release, digit 0 enters its ON phase (com=0001) on the cycle GAP+1 after the first un-reset edge.
- Load latency: data appears at the first ON phase of digit 0 in the next frame, never mid-frame. No tearing.
- Multiple loads within one frame: the last one wins.
- Reset mid-scan: all outputs go to their reset values immediately. Staged data is discarded.
- cnt width is $clog2(SCAN_DIV); idx width is $clog2(DIGITS), minimum 1.

## Configuration
- `SEG7_LZS_EN` defined:
  - When `lzs`=1, each digit i ≥ 1 is blanked if shadow value[i..DIGITS-1] are all zero.
  - A suppressed digit's dp is still shown.
  - Digit 0 is never suppressed.
  - Evaluated on shadow data, so it follows the same frame-boundary update.
- `SEG7_LZS_EN` undefined: `lzs` is ignored and no suppression logic is generated.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16-entry hex pattern constant;
  - the segment bit-position constants (DP=7, G=6 … A=0).
- Sub-module `drv7seg` is instanced once for the combinational nibble→segment decode of the selected shadow digit.
- Counters, buffers and suppression logic live in `seg7_scan`.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=8, GAP=2.
- Reset then no load → seg=00 for two full frames; com pulses 0001,0010,0100,1000 for cycles 2..7 of each digit period; frame pulses every 32 cycles.
- load value=16'h1234, dp=0, blank=0 → after the next boundary, digit0 seg=66, digit1 4F, digit2 5B, digit3 06; each has com=0 and seg=0 in cycles 0–1 of its digit period.
- load 16'h89AB mid-frame, then load 16'hCDEF in the same frame → only CDEF is displayed next frame (digit0=71, digit3=58); the current frame is unchanged.
- blank=4'b0100, dp=4'b0001, value=16'h0000 → digit2 seg=00 with com=0100 asserted; digit0 seg=BF.
- With SEG7_LZS_EN, lzs=1, value=16'h0050 → digit3 and digit2 seg=00; digit1=6D; digit0=3F. value=16'h0000 → only digit0 is lit (3F).
- Assert rst_n=0 during digit2's ON phase → seg and com are 0 in the same cycle; after release, blank=all-ones is restored.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table and segment bit positions.
package seg7_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Glyphs as gfedcba, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/drv7seg.sv
// Combinational hex nibble to segment decoder with decimal point pass-through.
module drv7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg_c
);

  logic [6:0] pat;

  always_comb begin
    pat           = HEX_PAT[nibble];
    seg_c         = '0;
    seg_c[SEG_A]  = pat[0];
    seg_c[SEG_B]  = pat[1];
    seg_c[SEG_C]  = pat[2];
    seg_c[SEG_D]  = pat[3];
    seg_c[SEG_E]  = pat[4];
    seg_c[SEG_F]  = pat[5];
    seg_c[SEG_G]  = pat[6];
    seg_c[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan.sv
// Double-buffered, time-multiplexed DIGITS-wide 7-segment scanner with per-digit ghost gap.
// Optional leading-zero suppression is built only when SEG7_LZS_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned GAP      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzs,
  input  logic                  load,
  output logic [SEG_W-1:0]      seg,
  output logic [DIGITS-1:0]     com,
  output logic                  frame
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] stg_value, sh_value;
  logic [DIGITS-1:0]   stg_dp, sh_dp, stg_blank, sh_blank;

  logic                cnt_last, idx_last, boundary, in_gap, suppress;
  logic [3:0]          sel_nibble;
  logic                sel_dp;
  logic [SEG_W-1:0]    dec_seg, seg_nxt;
  logic [DIGITS-1:0]   com_nxt;

  assign cnt_last   = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last   = (idx == IDX_W'(DIGITS - 1));
  assign boundary   = cnt_last && idx_last;
  assign in_gap     = (cnt < CNT_W'(GAP));
  assign sel_nibble = sh_value[4*idx +: 4];
  assign sel_dp     = sh_dp[idx];

  drv7seg u_drv7seg (
    .nibble (sel_nibble),
    .dp     (sel_dp),
    .seg_c  (dec_seg)
  );

`ifdef SEG7_LZS_EN
  // zero_above[i]: every shadow nibble from digit i up to the top digit is zero.
  logic [DIGITS-1:0] zero_above;

  always_comb begin
    logic run;
    run        = 1'b1;
    zero_above = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      run           = run & (sh_value[4*i +: 4] == 4'h0);
      zero_above[i] = run;
    end
  end

  assign suppress = lzs && (idx != '0) && zero_above[idx];
`else
  logic unused_lzs;
  assign unused_lzs = lzs;
  assign suppress   = 1'b0;
`endif

  // Next display drive: dark during the gap, then the selected shadow digit.
  always_comb begin
    seg_nxt = '0;
    com_nxt = '0;
    if (!in_gap) begin
      com_nxt = DIGITS'(1) << idx;
      if (sh_blank[idx]) begin
        seg_nxt = '0;
      end else if (suppress) begin
        seg_nxt[SEG_DP] = sel_dp;
      end else begin
        seg_nxt = dec_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      stg_value <= '0;
      stg_dp    <= '0;
      stg_blank <= '1;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      seg       <= '0;
      com       <= '0;
      frame     <= 1'b0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
      if (cnt_last) begin
        idx <= idx_last ? '0 : idx + IDX_W'(1);
      end
      if (load) begin
        stg_value <= value;
        stg_dp    <= dp;
        stg_blank <= blank;
      end
      // A load coinciding with the boundary bypasses the stale staging set.
      if (boundary) begin
        sh_value <= load ? value : stg_value;
        sh_dp    <= load ? dp    : stg_dp;
        sh_blank <= load ? blank : stg_blank;
      end
      seg   <= seg_nxt;
      com   <= com_nxt;
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, SCAN_DIV=8, GAP=2); honours SEG7_LZS_EN.
module tb_seg7_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int GAP      = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lzs = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  com;
  logic        frame;

  int checks = 0;
  int errors = 0;

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .lzs   (lzs),
    .load  (load),
    .seg   (seg),
    .com   (com),
    .frame (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h27;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h58;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Reference model: a scan position counter plus staged/shown digit arrays.
  int          pos, out_pos;
  logic [3:0]  m_stg_val [4];
  logic [3:0]  m_sh_val [4];
  logic [3:0]  m_stg_dp, m_stg_blank, m_sh_dp, m_sh_blank;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_com;
  logic        exp_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; out_pos = 0;
      exp_seg = '0; exp_com = '0; exp_frame = 1'b0;
      for (int i = 0; i < 4; i++) begin m_stg_val[i] = '0; m_sh_val[i] = '0; end
      m_stg_dp = '0; m_stg_blank = '1; m_sh_dp = '0; m_sh_blank = '1;
    end else begin
      int d, ph;
      logic supp;
      d = pos / SCAN_DIV;
      ph = pos % SCAN_DIV;
      supp = 1'b0;
`ifdef SEG7_LZS_EN
      if (lzs && d > 0) begin
        supp = 1'b1;
        for (int i = d; i < 4; i++) if (m_sh_val[i] != 4'h0) supp = 1'b0;
      end
`endif
      if (ph < GAP) begin
        exp_seg = '0; exp_com = '0;
      end else begin
        exp_com = 4'(1 << d);
        if (m_sh_blank[d])  exp_seg = '0;
        else if (supp)      exp_seg = {m_sh_dp[d], 7'h00};
        else                exp_seg = {m_sh_dp[d], hex7(m_sh_val[d])};
      end
      exp_frame = (pos == FRAME - 1);
      if (load) begin
        for (int i = 0; i < 4; i++) m_stg_val[i] = value[4*i +: 4];
        m_stg_dp = dp; m_stg_blank = blank;
      end
      if (pos == FRAME - 1) begin
        for (int i = 0; i < 4; i++) m_sh_val[i] = m_stg_val[i];
        m_sh_dp = m_stg_dp; m_sh_blank = m_stg_blank;
      end
      out_pos = pos;
      pos = (pos + 1) % FRAME;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("model_seg", 32'(seg), 32'(exp_seg));
    chk("model_com", 32'(com), 32'(exp_com));
    chk("model_frame", 32'(frame), 32'(exp_frame));
  endtask

  task automatic wait_pos(input int p);
    int g;
    g = 0;
    while (out_pos != p && g < 80) begin step(); g++; end
    if (out_pos != p) begin
      checks++; errors++;
      $display("FAIL wait_pos got %0d expected %0d", out_pos, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lzs;
    logic [3:0][7:0] expd;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                              input logic l, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
    vec_t r;
    r.value = v; r.dp = d; r.blank = b; r.lzs = l;
    r.expd = {e3, e2, e1, e0};
    return r;
  endfunction

  vec_t vecs [8];

  initial begin
    vecs[0] = mk(16'h1234, 4'b0000, 4'b0000, 1'b0, 8'h06, 8'h5B, 8'h4F, 8'h66);
    vecs[1] = mk(16'h0000, 4'b0001, 4'b0100, 1'b0, 8'h3F, 8'h00, 8'h3F, 8'hBF);
    vecs[2] = mk(16'hCDEF, 4'b0000, 4'b0000, 1'b0, 8'h58, 8'h5E, 8'h79, 8'h71);
`ifdef SEG7_LZS_EN
    vecs[3] = mk(16'h0050, 4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h6D, 8'h3F);
    vecs[4] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h3F);
    vecs[5] = mk(16'h0900, 4'b1000, 4'b0000, 1'b1, 8'h80, 8'h6F, 8'h3F, 8'h3F);
`else
    vecs[3] = mk(16'h0050, 4'b0000, 4'b0000, 1'b1, 8'h3F, 8'h3F, 8'h6D, 8'h3F);
    vecs[4] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
    vecs[5] = mk(16'h0900, 4'b1000, 4'b0000, 1'b1, 8'hBF, 8'h6F, 8'h3F, 8'h3F);
`endif
    vecs[6] = mk(16'h89AB, 4'b1010, 4'b0001, 1'b0, 8'hFF, 8'h6F, 8'hF7, 8'h00);
    vecs[7] = mk(16'h5678, 4'b0000, 4'b1000, 1'b0, 8'h00, 8'h7D, 8'h27, 8'h7F);

    // Reset state
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_com", 32'(com), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);

    // First ON phase of digit 0 lands on edge GAP+1 after release
    rst_n = 1'b1;
    for (int k = 1; k <= GAP + 1; k++) begin
      step();
      if (k == GAP) chk("first_gap_com", 32'(com), 32'h0);
      if (k == GAP + 1) chk("first_on_com", 32'(com), 32'h1);
    end
    repeat (2 * FRAME) step();

    // Table-driven vectors, each checked on the frame after its load
    for (int v = 0; v < 8; v++) begin
      lzs = vecs[v].lzs;
      do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
      wait_pos(FRAME - 1);
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (out_pos % SCAN_DIV == GAP) begin
          chk($sformatf("vec%0d_seg_d%0d", v, out_pos / SCAN_DIV), 32'(seg),
              32'(vecs[v].expd[out_pos / SCAN_DIV]));
          chk($sformatf("vec%0d_com_d%0d", v, out_pos / SCAN_DIV), 32'(com),
              32'(1 << (out_pos / SCAN_DIV)));
        end
        if (out_pos % SCAN_DIV == 0) begin
          chk($sformatf("vec%0d_gap_seg", v), 32'(seg), 32'h0);
          chk($sformatf("vec%0d_gap_com", v), 32'(com), 32'h0);
        end
      end
    end
    lzs = 1'b0;

    // Two loads in one frame: the last one wins, the current frame is untouched
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_pos(FRAME - 1);
    wait_pos(5);
    do_load(16'h89AB, 4'b0000, 4'b0000);
    repeat (3) step();
    do_load(16'hCDEF, 4'b0000, 4'b0000);
    wait_pos(2 * SCAN_DIV + GAP);
    chk("dbl_cur_frame_d2", 32'(seg), 32'h06);
    wait_pos(FRAME - 1);
    wait_pos(GAP);
    chk("dbl_d0", 32'(seg), 32'h71);
    wait_pos(3 * SCAN_DIV + GAP);
    chk("dbl_d3", 32'(seg), 32'h58);

    // Load on the boundary cycle bypasses stale staging
    wait_pos(10);
    do_load(16'h0003, 4'b0000, 4'b0000);
    wait_pos(FRAME - 2);
    do_load(16'h0007, 4'b0000, 4'b0000);
    wait_pos(GAP);
    chk("bypass_d0", 32'(seg), 32'h27);

    // Reset during digit 2 ON phase, with fresh data staged
    wait_pos(2 * SCAN_DIV + 1);
    do_load(16'h4444, 4'b1111, 4'b0000);
    wait_pos(2 * SCAN_DIV + 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg), 32'h0);
    chk("midrst_com", 32'(com), 32'h0);
    chk("midrst_frame", 32'(frame), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_pos(GAP);
    chk("dark_after_rst_seg", 32'(seg), 32'h0);
    chk("dark_after_rst_com", 32'(com), 32'h1);
    repeat (2 * FRAME) step();

    // Randomised loads against the model
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 20)) step();
      lzs = 1'($urandom);
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (2 * FRAME) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
